// File: rtl/hack_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hack_cpu_pkg
// Purpose  : Shared FSM encoding, instruction field positions and ALU comp
//            codes for the multi-cycle Hack CPU.
// Revision : 1.0
// ============================================================================
package hack_cpu_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_FETCH  = 3'd0;
    localparam state_t c_DECODE = 3'd1;
    localparam state_t c_MEM_RD = 3'd2;
    localparam state_t c_EXEC   = 3'd3;
    localparam state_t c_MEM_WR = 3'd4;

    // C-instruction field positions (identical for every DATA_W)
    localparam int unsigned c_BIT_A    = 12;
    localparam int unsigned c_COMP_MSB = 11;
    localparam int unsigned c_COMP_LSB = 6;
    localparam int unsigned c_BIT_D1   = 5;
    localparam int unsigned c_BIT_D2   = 4;
    localparam int unsigned c_BIT_D3   = 3;
    localparam int unsigned c_BIT_J1   = 2;
    localparam int unsigned c_BIT_J2   = 1;
    localparam int unsigned c_BIT_J3   = 0;

    // comp = {zx, nx, zy, ny, f, no}
    localparam logic [5:0] c_COMP_ZERO   = 6'b101010;
    localparam logic [5:0] c_COMP_ONE    = 6'b111111;
    localparam logic [5:0] c_COMP_NEG1   = 6'b111010;
    localparam logic [5:0] c_COMP_D      = 6'b001100;
    localparam logic [5:0] c_COMP_A      = 6'b110000;
    localparam logic [5:0] c_COMP_DPLUS1 = 6'b011111;
    localparam logic [5:0] c_COMP_DPLUSA = 6'b000010;

    function automatic logic jumpTaken(input logic [2:0] jmp, input logic zr, input logic ng);
        return (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hack_alu.sv
`default_nettype none
// ============================================================================
// Module   : hack_alu
// Purpose  : Combinational Hack ALU (zx,nx,zy,ny,f,no) over DATA_W bits.
// Revision : 1.0
// ============================================================================
module hack_alu #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] i_x,
    input  logic [DATA_W-1:0] i_y,
    input  logic [5:0]        i_comp,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zr,
    output logic              o_ng
);

    logic [DATA_W-1:0] w_x0;
    logic [DATA_W-1:0] w_x1;
    logic [DATA_W-1:0] w_y0;
    logic [DATA_W-1:0] w_y1;
    logic [DATA_W-1:0] w_f;

    assign w_x0     = i_comp[5] ? '0 : i_x;
    assign w_x1     = i_comp[4] ? ~w_x0 : w_x0;
    assign w_y0     = i_comp[3] ? '0 : i_y;
    assign w_y1     = i_comp[2] ? ~w_y0 : w_y0;
    assign w_f      = i_comp[1] ? (w_x1 + w_y1) : (w_x1 & w_y1);
    assign o_result = i_comp[0] ? ~w_f : w_f;
    assign o_zr     = (o_result == '0);
    assign o_ng     = o_result[DATA_W-1];

endmodule
`default_nettype wire

// File: rtl/hack_cpu_mc.sv
`default_nettype none
// ============================================================================
// Module   : hack_cpu_mc
// Purpose  : Multi-cycle parametrised Hack CPU with valid-qualified fetch,
//            req/ack data memory and a retired-instruction counter.
// Revision : 1.0
// ============================================================================
module hack_cpu_mc
    import hack_cpu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 15,
    parameter int PC_W     = 15,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic [PC_W-1:0]   pc,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] instruction,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] addressM,
    output logic [DATA_W-1:0] outM,
    input  logic [DATA_W-1:0] inM,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  instret
);

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_d;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] r_outM;
    logic              r_memReq;
    logic              r_memWe;
    logic [CNT_W-1:0]  r_instret;

    logic              w_isC;
    logic              w_aBit;
    logic [5:0]        w_comp;
    logic [DATA_W-1:0] w_y;
    logic [DATA_W-1:0] w_aluOut;
    logic              w_zr;
    logic              w_ng;
    logic              w_jump;
    logic [PC_W-1:0]   w_pcInc;
    logic              w_retire;

    assign w_isC   = r_ir[DATA_W-1];
    assign w_aBit  = r_ir[c_BIT_A];
    assign w_comp  = r_ir[c_COMP_MSB:c_COMP_LSB];
    assign w_y     = w_aBit ? r_mdr : r_a;
    assign w_jump  = jumpTaken(r_ir[c_BIT_J1:c_BIT_J3], w_zr, w_ng);
    assign w_pcInc = r_pc + PC_W'(1);

    hack_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_x      (r_d),
        .i_y      (w_y),
        .i_comp   (w_comp),
        .o_result (w_aluOut),
        .o_zr     (w_zr),
        .o_ng     (w_ng)
    );

    // A and MDR are untouched until retire, so the ALU result stays valid in MEM_WR
    assign w_retire = ((r_state == c_EXEC) && !r_ir[c_BIT_D3]) ||
                      ((r_state == c_MEM_WR) && mem_ack);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_FETCH;
            r_pc      <= PC_W'(RESET_PC);
            r_a       <= '0;
            r_d       <= '0;
            r_ir      <= '0;
            r_mdr     <= '0;
            r_outM    <= '0;
            r_memReq  <= 1'b0;
            r_memWe   <= 1'b0;
            r_instret <= '0;
        end else begin
            case (r_state)
                c_FETCH: begin
                    if (instr_valid) begin
                        r_ir    <= instruction;
                        r_state <= c_DECODE;
                    end
                end
                c_DECODE: begin
                    if (!w_isC) begin
                        r_a       <= {1'b0, r_ir[DATA_W-2:0]};
                        r_pc      <= w_pcInc;
                        r_instret <= r_instret + CNT_W'(1);
                        r_state   <= c_FETCH;
                    end else if (w_aBit) begin
                        r_memReq <= 1'b1;
                        r_memWe  <= 1'b0;
                        r_state  <= c_MEM_RD;
                    end else begin
                        r_state <= c_EXEC;
                    end
                end
                c_MEM_RD: begin
                    if (mem_ack) begin
                        r_mdr    <= inM;
                        r_memReq <= 1'b0;
                        r_state  <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    if (r_ir[c_BIT_D3]) begin
                        r_outM   <= w_aluOut;
                        r_memReq <= 1'b1;
                        r_memWe  <= 1'b1;
                        r_state  <= c_MEM_WR;
                    end
                end
                c_MEM_WR: begin
                    if (mem_ack) begin
                        r_memReq <= 1'b0;
                        r_memWe  <= 1'b0;
                    end
                end
                default: r_state <= c_FETCH;
            endcase

            if (w_retire) begin
                if (r_ir[c_BIT_D1]) r_a <= w_aluOut;
                if (r_ir[c_BIT_D2]) r_d <= w_aluOut;
                // Jump target uses A as it was before this instruction's writeback
                r_pc      <= w_jump ? r_a[PC_W-1:0] : w_pcInc;
                r_instret <= r_instret + CNT_W'(1);
                r_state   <= c_FETCH;
            end
        end
    end

    assign pc       = r_pc;
    assign mem_req  = r_memReq;
    assign mem_we   = r_memWe;
    assign addressM = r_a[ADDR_W-1:0];
    assign outM     = r_outM;
    assign instret  = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_hack_cpu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_hack_cpu_mc
// Purpose  : Directed self-checking bench for hack_cpu_mc (16- and 32-bit).
// Revision : 1.0
// ============================================================================
module tb_hack_cpu_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] pc;
    logic        instrValid;
    logic [15:0] instruction;
    logic        memReq;
    logic        memWe;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic [15:0] inM;
    logic        memAck;
    logic [31:0] instret;

    logic [14:0] pc32;
    logic        instrValid32;
    logic [31:0] instruction32;
    logic        memReq32;
    logic        memWe32;
    logic [14:0] addressM32;
    logic [31:0] outM32;
    logic [31:0] instret32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hack_cpu_mc dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .instr_valid (instrValid),
        .instruction (instruction),
        .mem_req     (memReq),
        .mem_we      (memWe),
        .addressM    (addressM),
        .outM        (outM),
        .inM         (inM),
        .mem_ack     (memAck),
        .instret     (instret)
    );

    hack_cpu_mc #(
        .DATA_W (32)
    ) dut32 (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc32),
        .instr_valid (instrValid32),
        .instruction (instruction32),
        .mem_req     (memReq32),
        .mem_we      (memWe32),
        .addressM    (addressM32),
        .outM        (outM32),
        .inM         (32'h0),
        .mem_ack     (1'b0),
        .instret     (instret32)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runA(input logic [15:0] instr);
        instruction = instr;
        step();
        chk("a_no_req", {63'd0, memReq}, 64'd0);
        step();
    endtask

    task automatic runC(input logic [15:0] instr);
        instruction = instr;
        step(3);
    endtask

    task automatic run32(input logic [31:0] instr, input int cycles);
        instruction32 = instr;
        step(cycles);
    endtask

    initial begin
        reset         = 1'b1;
        instrValid    = 1'b0;
        instruction   = 16'h0;
        inM           = 16'h0;
        memAck        = 1'b0;
        instrValid32  = 1'b0;
        instruction32 = 32'h0;
        #2;
        chk("rst_pc", {49'd0, pc}, 64'd0);
        chk("rst_req", {62'd0, memReq, memWe}, 64'd0);
        chk("rst_outM", {48'd0, outM}, 64'd0);
        chk("rst_instret", {32'd0, instret}, 64'd0);
        step();
        reset = 1'b0;

        // FETCH waits without instr_valid
        step(2);
        chk("idle_pc", {49'd0, pc}, 64'd0);
        chk("idle_instret", {32'd0, instret}, 64'd0);

        instrValid = 1'b1;
        runA(16'h0005);
        chk("a5_A", {48'd0, dut.r_a}, 64'd5);
        chk("a5_pc", {49'd0, pc}, 64'd1);
        chk("a5_instret", {32'd0, instret}, 64'd1);

        runC(16'hEC10);
        chk("dA_D", {48'd0, dut.r_d}, 64'd5);
        chk("dA_pc", {49'd0, pc}, 64'd2);
        chk("dA_instret", {32'd0, instret}, 64'd2);

        // M=D+1 with three ack wait states
        instruction = 16'hE7C8;
        step(3);
        repeat (3) begin
            chk("wr_req_we", {62'd0, memReq, memWe}, 64'd3);
            chk("wr_addr", {49'd0, addressM}, 64'd5);
            chk("wr_outM", {48'd0, outM}, 64'd6);
            chk("wr_pc", {49'd0, pc}, 64'd2);
            step();
        end
        memAck = 1'b1;
        step();
        memAck = 1'b0;
        chk("wr_done_req", {63'd0, memReq}, 64'd0);
        chk("wr_done_pc", {49'd0, pc}, 64'd3);
        chk("wr_done_instret", {32'd0, instret}, 64'd3);

        // D=M with two ack wait states
        instruction = 16'hFC10;
        step(2);
        repeat (2) begin
            chk("rd_req_we", {62'd0, memReq, memWe}, 64'd2);
            step();
        end
        inM    = 16'h1234;
        memAck = 1'b1;
        step();
        memAck = 1'b0;
        inM    = 16'h0;
        chk("rd_req_drop", {63'd0, memReq}, 64'd0);
        step();
        chk("rd_D", {48'd0, dut.r_d}, 64'h1234);
        chk("rd_A", {48'd0, dut.r_a}, 64'd5);
        chk("rd_pc", {49'd0, pc}, 64'd4);

        runA(16'h000A);
        runC(16'hE301);
        chk("jgt_taken_pc", {49'd0, pc}, 64'd10);
        chk("jgt_instret", {32'd0, instret}, 64'd6);

        runA(16'h0000);
        runC(16'hEA87);
        chk("jmp_pc", {49'd0, pc}, 64'd0);

        runC(16'hEE90);
        chk("neg1_D", {48'd0, dut.r_d}, 64'hFFFF);
        runC(16'hE301);
        chk("jgt_not_taken_pc", {49'd0, pc}, 64'd2);
        chk("jgt_nt_instret", {32'd0, instret}, 64'd10);

        // pc wraps from 2^15-1 to 0
        runA(16'h7FFF);
        runC(16'hEA87);
        chk("jmp_max_pc", {49'd0, pc}, 64'h7FFF);
        runA(16'h0003);
        chk("pc_wrap", {49'd0, pc}, 64'd0);

        // Reset in the middle of a write
        instruction = 16'hEE88;
        step(3);
        instrValid = 1'b0;
        chk("mid_wr_req", {62'd0, memReq, memWe}, 64'd3);
        chk("mid_wr_outM", {48'd0, outM}, 64'hFFFF);
        reset = 1'b1;
        #1;
        chk("async_req", {62'd0, memReq, memWe}, 64'd0);
        chk("async_pc", {49'd0, pc}, 64'd0);
        chk("async_AD", {dut.r_a, dut.r_d}, 64'd0);
        chk("async_instret", {32'd0, instret}, 64'd0);
        step();
        reset  = 1'b0;
        memAck = 1'b1;
        step();
        memAck = 1'b0;
        chk("late_ack_req", {63'd0, memReq}, 64'd0);
        chk("late_ack_pc", {49'd0, pc}, 64'd0);
        chk("late_ack_instret", {32'd0, instret}, 64'd0);
        instrValid = 1'b1;
        runA(16'h0007);
        chk("post_rst_pc", {49'd0, pc}, 64'd1);
        chk("post_rst_A", {48'd0, dut.r_a}, 64'd7);
        instrValid = 1'b0;

        // 32-bit datapath
        instrValid32 = 1'b1;
        run32(32'h7FFF_FFFF, 2);
        chk("w32_A", {32'd0, dut32.r_a}, 64'h7FFF_FFFF);
        run32(32'hFFFF_EC10, 3);
        chk("w32_DA", {32'd0, dut32.r_d}, 64'h7FFF_FFFF);
        run32(32'h8000_EE90, 3);
        chk("w32_neg1", {32'd0, dut32.r_d}, 64'hFFFF_FFFF);
        run32(32'h8000_E7D2, 3);
        chk("w32_wrap_D", {32'd0, dut32.r_d}, 64'd0);
        chk("w32_jeq_pc", {49'd0, pc32}, 64'h7FFF);
        chk("w32_instret", {32'd0, instret32}, 64'd4);
        instrValid32 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hack_cpu_mc.md
Name: hack_cpu_mc

Overview:
Multi-cycle, parametrised successor to the single-cycle Hack CPU. Same Hack A/C instruction semantics, generalised in data, address and PC width. Instruction memory is reached through a valid-qualified fetch; data memory through a req/ack handshake with arbitrary wait states. Adds a retired-instruction counter; sits between the instruction ROM and the data RAM / memory-mapped I/O fabric.

Parameters:
DATA_W, 16, width of A, D, ALU, instruction, inM and outM (minimum 16)
ADDR_W, 15, data-memory address width; addressM = A[ADDR_W-1:0]
PC_W, 15, program counter width; jump target = A[PC_W-1:0]
RESET_PC, 0, PC value loaded on reset
CNT_W, 32, width of the instret counter

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
pc  out  PC_W  fetch address (registered)
instr_valid  in  1  instruction word valid for current pc
instruction  in  DATA_W  instruction word
mem_req  out  1  data-memory request, held until mem_ack
mem_we  out  1  1 = write (Hack writeM), 0 = read; valid only with mem_req
addressM  out  ADDR_W  data address = A[ADDR_W-1:0]
outM  out  DATA_W  write data (registered ALU result)
inM  in  DATA_W  read data, sampled on the cycle mem_ack=1
mem_ack  in  1  completes the outstanding request
instret  out  CNT_W  count of retired instructions, wraps to 0

Behaviour:
- Reset (async, immediate): state=FETCH, pc=RESET_PC, A=D=0, IR=0, mem_req=0, mem_we=0, outM=0, instret=0; any outstanding request is abandoned.
- Decode: IR[DATA_W-1]=0 is an A-instruction, A <= {0, IR[DATA_W-2:0]}. Otherwise a C-instruction with a=IR[12], comp=IR[11:6], dest d1(A)/d2(D)/d3(M)=IR[5:3], jump j1/j2/j3=IR[2:0]; IR bits DATA_W-1..13 above bit 15 and bits 14:13 are ignored.
- ALU: standard Hack zx,nx,zy,ny,f,no over DATA_W bits; x=D, y=(a ? MDR : A); add wraps modulo 2^DATA_W; zr=(out==0), ng=out[DATA_W-1].
- Jump condition: (j1&ng)|(j2&zr)|(j3&~ng&~zr). Target is the A value held at instruction start (pre-writeback), truncated to PC_W; otherwise pc+1, wrapping 2^PC_W-1 -> 0.
- FSM:
  - FETCH: wait for instr_valid; on 1 latch IR -> DECODE. pc stable throughout.
  - DECODE: A-instr: write A, pc+1, instret+1 -> FETCH. C-instr with a=1: mem_req=1, mem_we=0 -> MEM_RD. Else -> EXEC.
  - MEM_RD: hold mem_req; on mem_ack latch inM into MDR, drop mem_req -> EXEC.
  - EXEC: compute ALU. If d3: outM <= result, mem_req=1, mem_we=1 -> MEM_WR. Else retire -> FETCH.
  - MEM_WR: hold mem_req/mem_we/outM/addressM; on mem_ack retire -> FETCH.
- Retire means: update A (d1) and D (d2), update pc, increment instret, all in one edge.
- Latency: A-instr 2 cycles; C-instr without M 3 cycles; each M access adds 1 cycle plus ack wait states.
- addressM always reflects the current A. Because A writeback is deferred to retire, addressM is stable across MEM_RD/MEM_WR.
- mem_ack outside MEM_RD/MEM_WR is ignored. instr_valid outside FETCH is ignored.
- A C-instruction with a=1 and d3=1 performs a read then a write, in that order.

Decomposition:
- Package hack_cpu_pkg holds: FSM state enum (FETCH, DECODE, MEM_RD, EXEC, MEM_WR); instruction field bit positions; named comp codes used by the bench.
- One sub-module, hack_alu (parametrised DATA_W, purely combinational), instantiated once.

Test Plan:
- Reset, then instruction=0x0005 with instr_valid=1 -> after 2 cycles A=5, pc=1, instret=1, mem_req never asserted.
- Next 0xEC10 (D=A) -> 3 cycles later D=5, pc=2, instret=2.
- 0xE7C8 (M=D+1), mem_ack held low 3 cycles -> mem_req=1, mem_we=1, addressM=5, outM=6 stable, pc=2 throughout; ack -> pc=3, mem_req=0 next cycle.
- 0xFC10 (D=M), inM=0x1234, ack after 2 wait cycles -> mem_we=0 during request, D=0x1234, A unchanged.
- @10 then 0xE301 (D;JGT) with D=0x1234 -> pc=10. Then 0xEA87 (0;JMP) with A=0 -> pc=0. D=0xFFFF with JGT -> pc increments.
- Reset asserted mid-MEM_WR -> mem_req/mem_we drop with reset (before next edge), pc=0, A=D=instret=0; a late mem_ack after reset release is ignored.
- DATA_W=32 build: A-instruction 0x7FFF_FFFF -> A=0x7FFF_FFFF; D+1 on 0xFFFF_FFFF wraps to 0, zr=1.
